// File: rtl/game_pkg.sv
// Shared game constants: tile types, one-hot player edge codes, contact FSM
// states and the captured hit record used by the step collision logic.
package game_pkg;

  localparam logic [2:0] FREE  = 3'b000;
  localparam logic [2:0] REGU  = 3'b001;
  localparam logic [2:0] BRAKE = 3'b110;

  localparam logic [3:0] EDGE_NONE   = 4'b0000;
  localparam logic [3:0] EDGE_BOTTOM = 4'b0001;
  localparam logic [3:0] EDGE_RIGHT  = 4'b0010;
  localparam logic [3:0] EDGE_TOP    = 4'b0100;
  localparam logic [3:0] EDGE_LEFT   = 4'b1000;

  // Playfield is 640x448 in 64-pixel tiles.
  localparam int GRID_COLS = 10;
  localparam int GRID_ROWS = 7;

  typedef enum logic [1:0] {
    NO_CONTACT   = 2'd0,
    CONTACT      = 2'd1,
    RELEASE_WAIT = 2'd2
  } contact_state_t;

  typedef struct packed {
    logic [3:0] edge_code;
    logic [3:0] col;
    logic [2:0] row;
  } hit_info_t;

endpackage

// File: rtl/step_collision_detector_if.sv
// Pixel-stream inputs and contact outputs of the step collision detector.
interface step_collision_detector_if;

  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        playerDrawingRequest;
  logic [10:0] playerOffsetX;
  logic [10:0] playerOffsetY;
  logic        stepDrawingRequest;
  logic [2:0]  step_type;

  logic        breaking_step_collision;
  logic [3:0]  HitEdgeCode;
  logic [3:0]  hitTileCol;
  logic [2:0]  hitTileRow;

  modport master (
    output startOfFrame, pixelX, pixelY, playerDrawingRequest,
           playerOffsetX, playerOffsetY, stepDrawingRequest, step_type,
    input  breaking_step_collision, HitEdgeCode, hitTileCol, hitTileRow
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, playerDrawingRequest,
           playerOffsetX, playerOffsetY, stepDrawingRequest, step_type,
    output breaking_step_collision, HitEdgeCode, hitTileCol, hitTileRow
  );

endinterface

// File: rtl/edge_classifier.sv
// Maps a pixel offset inside the player sprite to the one-hot edge band it
// falls in; bottom wins over top, then left, then right.
module edge_classifier
  import game_pkg::*;
#(
  parameter int PLAYER_SIZE = 32,
  parameter int EDGE_MARGIN = 4
) (
  input  logic [10:0] i_off_x,
  input  logic [10:0] i_off_y,
  output logic [3:0]  o_edge_code
);

  localparam logic [10:0] LOW_BAND  = 11'(EDGE_MARGIN);
  localparam logic [10:0] HIGH_BAND = 11'(PLAYER_SIZE - EDGE_MARGIN);

  always_comb begin
    if (i_off_y >= HIGH_BAND)      o_edge_code = EDGE_BOTTOM;
    else if (i_off_y < LOW_BAND)   o_edge_code = EDGE_TOP;
    else if (i_off_x < LOW_BAND)   o_edge_code = EDGE_LEFT;
    else if (i_off_x >= HIGH_BAND) o_edge_code = EDGE_RIGHT;
    else                           o_edge_code = EDGE_NONE;
  end

endmodule

// File: rtl/step_collision_detector.sv
// Counts player/BRAKE-tile overlap per frame and reports a debounced contact
// level plus the edge and tile of the first in-grid overlap pixel.
module step_collision_detector
  import game_pkg::*;
#(
  parameter int PLAYER_SIZE    = 32,
  parameter int EDGE_MARGIN    = 4,
  parameter int MIN_HIT_PIXELS = 4,
  parameter int RELEASE_FRAMES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  step_collision_detector_if.slave   bus
);

  localparam logic [7:0] MIN_HITS   = 8'(MIN_HIT_PIXELS);
  localparam logic [7:0] REL_FRAMES = 8'(RELEASE_FRAMES);

  logic           w_qual;
  logic           w_in_grid;
  logic           w_frame_hit;
  logic           w_load_out;
  logic           w_clear_out;
  logic [4:0]     w_col;
  logic [4:0]     w_row;
  logic [3:0]     w_edge_code;
  hit_info_t      w_pix_info;
  logic [7:0]     w_clear_cnt_next;
  contact_state_t w_state_next;

  contact_state_t r_state;
  logic [7:0]     r_clear_cnt;
  logic [7:0]     r_pix_cnt;
  logic           r_cap_valid;
  hit_info_t      r_cap;
  logic           r_collision;
  hit_info_t      r_out;

  edge_classifier #(
    .PLAYER_SIZE (PLAYER_SIZE),
    .EDGE_MARGIN (EDGE_MARGIN)
  ) u_edge_classifier (
    .i_off_x     (bus.playerOffsetX),
    .i_off_y     (bus.playerOffsetY),
    .o_edge_code (w_edge_code)
  );

  assign w_qual      = bus.playerDrawingRequest && bus.stepDrawingRequest &&
                       (bus.step_type == BRAKE);
  assign w_col       = bus.pixelX[10:6];
  assign w_row       = bus.pixelY[10:6];
  assign w_in_grid   = (w_col < 5'(GRID_COLS)) && (w_row < 5'(GRID_ROWS));
  assign w_pix_info  = {w_edge_code, w_col[3:0], w_row[2:0]};
  assign w_frame_hit = bus.startOfFrame && (r_pix_cnt >= MIN_HITS);

  // The start-of-frame pixel already belongs to the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_cnt   <= '0;
      r_cap_valid <= 1'b0;
      r_cap       <= '0;
    end else if (bus.startOfFrame) begin
      r_pix_cnt   <= w_qual ? 8'd1 : 8'd0;
      r_cap_valid <= w_qual && w_in_grid;
      r_cap       <= (w_qual && w_in_grid) ? w_pix_info : '0;
    end else begin
      if (w_qual && (r_pix_cnt != 8'hFF))
        r_pix_cnt <= r_pix_cnt + 8'd1;
      if (w_qual && w_in_grid && !r_cap_valid) begin
        r_cap_valid <= 1'b1;
        r_cap       <= w_pix_info;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= NO_CONTACT;
      r_clear_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_clear_cnt <= w_clear_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_clear_cnt_next = r_clear_cnt;
    if (bus.startOfFrame) begin
      unique case (r_state)
        NO_CONTACT: begin
          if (w_frame_hit) w_state_next = CONTACT;
        end
        CONTACT: begin
          if (!w_frame_hit) begin
            if (REL_FRAMES <= 8'd1) begin
              w_state_next     = NO_CONTACT;
              w_clear_cnt_next = '0;
            end else begin
              w_state_next     = RELEASE_WAIT;
              w_clear_cnt_next = 8'd1;
            end
          end
        end
        RELEASE_WAIT: begin
          if (w_frame_hit) begin
            w_state_next     = CONTACT;
            w_clear_cnt_next = '0;
          end else if ((r_clear_cnt + 8'd1) >= REL_FRAMES) begin
            w_state_next     = NO_CONTACT;
            w_clear_cnt_next = '0;
          end else begin
            w_clear_cnt_next = r_clear_cnt + 8'd1;
          end
        end
        default: begin
          w_state_next     = NO_CONTACT;
          w_clear_cnt_next = '0;
        end
      endcase
    end
  end

  // Any hit refreshes the outputs; a fall back to NO_CONTACT zeroes them.
  always_comb begin
    w_load_out  = 1'b0;
    w_clear_out = 1'b0;
    if (bus.startOfFrame) begin
      w_load_out  = w_frame_hit;
      w_clear_out = (w_state_next == NO_CONTACT) && (r_state != NO_CONTACT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_collision <= 1'b0;
      r_out       <= '0;
    end else if (w_load_out) begin
      r_collision <= 1'b1;
      r_out       <= r_cap;
    end else if (w_clear_out) begin
      r_collision <= 1'b0;
      r_out       <= '0;
    end
  end

  assign bus.breaking_step_collision = r_collision;
  assign bus.HitEdgeCode             = r_out.edge_code;
  assign bus.hitTileCol              = r_out.col;
  assign bus.hitTileRow              = r_out.row;

endmodule

// File: tb/tb_step_collision_detector.sv
// Randomized frame-level stimulus with a reference model feeding a scoreboard
// queue; a monitor compares outputs after every frame start and reset.
module tb_step_collision_detector;
  import game_pkg::*;

  localparam int PS   = 32;
  localparam int EM   = 4;
  localparam int MINH = 4;
  localparam int RELF = 2;

  logic clk = 1'b0;
  logic reset;

  step_collision_detector_if bus ();

  step_collision_detector #(
    .PLAYER_SIZE    (PS),
    .EDGE_MARGIN    (EM),
    .MIN_HIT_PIXELS (MINH),
    .RELEASE_FRAMES (RELF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         coll;
    logic [3:0] edge_code;
    logic [3:0] col;
    logic [2:0] row;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: overlap statistics of the frame in progress plus the
  // number of consecutive clear frames since the last hit frame.
  int   m_cnt       = 0;
  bit   m_cap_valid = 1'b0;
  exp_t m_cap;
  bit   m_contact   = 1'b0;
  int   m_miss      = 0;
  exp_t m_out;
  int   bnd[6]      = '{0, 3, 4, 27, 28, 31};

  function automatic exp_t zero_exp();
    exp_t z;
    z.coll = 1'b0; z.edge_code = 4'd0; z.col = 4'd0; z.row = 3'd0;
    return z;
  endfunction

  function automatic logic [3:0] edge_of(int ox, int oy);
    if (oy >= PS - EM) return 4'b0001;
    if (oy < EM)       return 4'b0100;
    if (ox < EM)       return 4'b1000;
    if (ox >= PS - EM) return 4'b0010;
    return 4'b0000;
  endfunction

  function automatic int pick_off();
    if ($urandom_range(1, 0) == 1) return bnd[$urandom_range(5, 0)];
    return int'($urandom_range(31, 0));
  endfunction

  task automatic drive_cycle(bit sof, bit rst, bit pl, bit st, logic [2:0] ty,
                             int x, int y, int ox, int oy);
    bit   qual;
    int   sat_cnt;
    exp_t c;
    reset                    = rst;
    bus.startOfFrame         = sof;
    bus.playerDrawingRequest = pl;
    bus.stepDrawingRequest   = st;
    bus.step_type            = ty;
    bus.pixelX               = 11'(x);
    bus.pixelY               = 11'(y);
    bus.playerOffsetX        = 11'(ox);
    bus.playerOffsetY        = 11'(oy);
    qual = pl && st && (ty == BRAKE);
    if (rst) begin
      m_cnt = 0; m_cap_valid = 1'b0; m_contact = 1'b0; m_miss = 0;
      m_out = zero_exp();
      exp_q.push_back(m_out);
    end else begin
      if (sof) begin
        sat_cnt = (m_cnt > 255) ? 255 : m_cnt;
        if (sat_cnt >= MINH) begin
          m_contact = 1'b1;
          m_miss    = 0;
          m_out     = m_cap_valid ? m_cap : zero_exp();
          m_out.coll = 1'b1;
        end else if (m_contact) begin
          m_miss++;
          if (m_miss >= RELF) begin
            m_contact = 1'b0;
            m_out     = zero_exp();
          end
        end
        exp_q.push_back(m_out);
        m_cnt = 0;
        m_cap_valid = 1'b0;
      end
      if (qual) begin
        m_cnt++;
        if (!m_cap_valid && (x / 64) < 10 && (y / 64) < 7) begin
          m_cap_valid = 1'b1;
          c.coll = 1'b1; c.edge_code = edge_of(ox, oy);
          c.col = 4'(x / 64); c.row = 3'(y / 64);
          m_cap = c;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // fixed=1 places the qualifying pixels first along row y=140 from x=200.
  task automatic run_frame(int n_qual, int len, int nq_kind, int rst_at,
                           bit fixed, int fx_ox, int fx_oy);
    int remaining = n_qual;
    for (int c = 0; c < len; c++) begin
      bit q;
      int k;
      if (fixed) q = (c < n_qual);
      else       q = (remaining > 0) && (int'($urandom_range(len - c - 1, 0)) < remaining);
      if (q) remaining--;
      if (c == rst_at) begin
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, FREE, 0, 0, 0, 0);
      end else if (q && fixed) begin
        drive_cycle(c == 0, 1'b0, 1'b1, 1'b1, BRAKE, 200 + c, 140, fx_ox, fx_oy);
      end else if (q) begin
        drive_cycle(c == 0, 1'b0, 1'b1, 1'b1, BRAKE,
                    int'($urandom_range(767, 0)), int'($urandom_range(511, 0)),
                    pick_off(), pick_off());
      end else if (nq_kind == 1) begin
        drive_cycle(c == 0, 1'b0, 1'b1, 1'b1, REGU,
                    int'($urandom_range(639, 0)), int'($urandom_range(447, 0)),
                    pick_off(), pick_off());
      end else begin
        k = int'($urandom_range(2, 0));
        drive_cycle(c == 0, 1'b0, k != 0, k != 1,
                    (k == 2) ? 3'($urandom_range(5, 0)) : 3'($urandom_range(7, 0)),
                    int'($urandom_range(767, 0)), int'($urandom_range(511, 0)),
                    pick_off(), pick_off());
      end
    end
  endtask

  task automatic check(string nm, exp_t e);
    n_checks++;
    if (bus.breaking_step_collision !== e.coll || bus.HitEdgeCode !== e.edge_code ||
        bus.hitTileCol !== e.col || bus.hitTileRow !== e.row) begin
      n_fail++;
      $display("FAIL %s t=%0t got coll=%b edge=%b col=%0d row=%0d required coll=%b edge=%b col=%0d row=%0d",
               nm, $time, bus.breaking_step_collision, bus.HitEdgeCode, bus.hitTileCol,
               bus.hitTileRow, e.coll, e.edge_code, e.col, e.row);
    end
  endtask

  // Monitor: an output update is due one cycle after each frame start/reset.
  bit   evt_d     = 1'b0;
  bit   have_hold = 1'b0;
  exp_t hold;

  always @(posedge clk) evt_d <= bus.startOfFrame || reset;

  always @(negedge clk) begin
    if (evt_d) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty t=%0t got an output update, required a queued expectation", $time);
      end else begin
        hold = exp_q.pop_front();
        have_hold = 1'b1;
        check("frame_update", hold);
        $display("update t=%0t coll=%b edge=%b col=%0d row=%0d",
                 $time, bus.breaking_step_collision, bus.HitEdgeCode,
                 bus.hitTileCol, bus.hitTileRow);
      end
    end else if (have_hold) begin
      check("hold_stable", hold);
    end
  end

  int nopts[10] = '{0, 0, 1, 3, 4, 5, 8, 20, 0, 12};

  initial begin
    m_out = zero_exp();
    m_cap = zero_exp();
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, FREE, 0, 0, 0, 0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, FREE, 0, 0, 0, 0);
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, FREE, 0, 0, 0, 0);

    run_frame(3, 20, 0, -1, 1'b0, 0, 0);      // below threshold
    run_frame(10, 20, 0, -1, 1'b1, 10, 30);   // bottom edge over tile (3,2)
    run_frame(0, 15, 0, -1, 1'b0, 0, 0);
    run_frame(0, 15, 0, -1, 1'b0, 0, 0);
    run_frame(0, 15, 0, -1, 1'b0, 0, 0);
    run_frame(10, 20, 0, -1, 1'b0, 0, 0);     // contact, clear, contact
    run_frame(0, 15, 0, -1, 1'b0, 0, 0);
    run_frame(10, 20, 0, -1, 1'b0, 0, 0);
    run_frame(0, 15, 0, -1, 1'b0, 0, 0);
    run_frame(0, 15, 0, -1, 1'b0, 0, 0);
    run_frame(0, 15, 0, -1, 1'b0, 0, 0);
    run_frame(0, 50, 1, -1, 1'b0, 0, 0);      // REGU overlap only
    run_frame(4, 12, 0, -1, 1'b0, 0, 0);      // exactly at threshold
    run_frame(0, 10, 0, -1, 1'b0, 0, 0);
    run_frame(0, 10, 0, -1, 1'b0, 0, 0);
    run_frame(256, 265, 0, -1, 1'b0, 0, 0);   // counter saturation
    run_frame(257, 262, 0, -1, 1'b0, 0, 0);
    run_frame(0, 10, 0, -1, 1'b0, 0, 0);
    run_frame(0, 10, 0, -1, 1'b0, 0, 0);
    run_frame(0, 10, 0, -1, 1'b0, 0, 0);
    run_frame(10, 20, 0, -1, 1'b1, 10, 30);
    run_frame(6, 30, 0, 10, 1'b1, 5, 15);     // hit on frame start, then reset
    run_frame(0, 15, 0, -1, 1'b0, 0, 0);
    run_frame(0, 15, 0, -1, 1'b0, 0, 0);

    for (int f = 0; f < 150; f++) begin
      int n, len, rst_at;
      n      = nopts[$urandom_range(9, 0)];
      len    = n + int'($urandom_range(20, 2));
      rst_at = ($urandom_range(19, 0) == 0) ? int'($urandom_range(len - 1, 1)) : -1;
      run_frame(n, len, ($urandom_range(9, 0) == 0) ? 1 : 0, rst_at, 1'b0, 0, 0);
    end

    run_frame(0, 6, 0, -1, 1'b0, 0, 0);
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, FREE, 0, 0, 0, 0);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending expectations, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
